// File: rtl/ex_flag_stage_pkg.sv
// Shared encodings for the EX-stage flag update class and branch conditions.
package ex_flag_stage_pkg;

    typedef enum logic [1:0] {
        FC_NONE = 2'b00,
        FC_Z    = 2'b01,
        FC_NZV  = 2'b10,
        FC_RSVD = 2'b11
    } fclass_e;

    typedef enum logic [2:0] {
        NE     = 3'b000,
        EQ     = 3'b001,
        GT     = 3'b010,
        LT     = 3'b011,
        GE     = 3'b100,
        LE     = 3'b101,
        OV     = 3'b110,
        UNCOND = 3'b111
    } br_cond_e;

endpackage

// File: rtl/ex_flag_stage_br_cond_eval.sv
// Combinational branch-condition decoder over N/Z/V.
module br_cond_eval
    import ex_flag_stage_pkg::*;
(
    input  logic       n,
    input  logic       z,
    input  logic       v,
    input  logic [2:0] cond,
    output logic       taken
);

    br_cond_e cond_e;
    assign cond_e = br_cond_e'(cond);

    always_comb begin
        taken = 1'b0;
        unique case (cond_e)
            NE:     taken = ~z;
            EQ:     taken = z;
            GT:     taken = ~z & ~n;
            LT:     taken = n;
            GE:     taken = z | (~z & ~n);
            LE:     taken = n | z;
            OV:     taken = v;
            UNCOND: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register plus architectural N/Z/V flags with a same-cycle
// bypass feeding the branch decision for an instruction in ID.
module ex_flag_stage
    import ex_flag_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [15:0] ex_result,
    input  logic        ex_n,
    input  logic        ex_v,
    input  logic [1:0]  ex_fclass,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_valid,
    input  logic [2:0]  br_cond,
    output logic        mem_valid,
    output logic [15:0] mem_result,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_v,
    output logic        br_taken
);

    logic        mem_valid_q;
    logic [15:0] mem_result_q;
    logic        flag_n_q, flag_z_q, flag_v_q;

    logic commit, upd_nzv, upd_z, z_calc;
    logic eff_n, eff_z, eff_v, cond_taken;

    // Reset suppresses commit so nothing is bypassed or loaded during reset.
    assign commit  = ex_valid & ~stall & ~flush & ~rst;
    assign upd_nzv = commit & (ex_fclass == FC_NZV);
    assign upd_z   = commit & ((ex_fclass == FC_NZV) | (ex_fclass == FC_Z));
    assign z_calc  = (ex_result == 16'h0000);

    assign eff_n = upd_nzv ? ex_n   : flag_n_q;
    assign eff_z = upd_z   ? z_calc : flag_z_q;
    assign eff_v = upd_nzv ? ex_v   : flag_v_q;

    br_cond_eval u_br_cond_eval (
        .n     (eff_n),
        .z     (eff_z),
        .v     (eff_v),
        .cond  (br_cond),
        .taken (cond_taken)
    );

    assign br_taken = br_valid & cond_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q  <= 1'b0;
            mem_result_q <= 16'h0000;
            flag_n_q     <= 1'b0;
            flag_z_q     <= 1'b0;
            flag_v_q     <= 1'b0;
        end else begin
            if (flush) begin
                mem_valid_q <= 1'b0;
            end else if (!stall) begin
                mem_valid_q <= ex_valid;
                if (ex_valid) begin
                    mem_result_q <= ex_result;
                end
            end
            if (upd_nzv) begin
                flag_n_q <= ex_n;
                flag_v_q <= ex_v;
            end
            if (upd_z) begin
                flag_z_q <= z_calc;
            end
        end
    end

    assign mem_valid  = mem_valid_q;
    assign mem_result = mem_result_q;
    assign flag_n     = flag_n_q;
    assign flag_z     = flag_z_q;
    assign flag_v     = flag_v_q;

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed self-checking bench for ex_flag_stage.
module tb_ex_flag_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [15:0] ex_result;
    logic        ex_n, ex_v;
    logic [1:0]  ex_fclass;
    logic        stall, flush;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic        mem_valid;
    logic [15:0] mem_result;
    logic        flag_n, flag_z, flag_v;
    logic        br_taken;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_flag_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_result  (ex_result),
        .ex_n       (ex_n),
        .ex_v       (ex_v),
        .ex_fclass  (ex_fclass),
        .stall      (stall),
        .flush      (flush),
        .br_valid   (br_valid),
        .br_cond    (br_cond),
        .mem_valid  (mem_valid),
        .mem_result (mem_result),
        .flag_n     (flag_n),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .br_taken   (br_taken)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic mv, input logic [15:0] mr,
                               input logic n, input logic z, input logic v);
        check({tag, ".mem_valid"},  {15'd0, mem_valid}, {15'd0, mv});
        check({tag, ".mem_result"}, mem_result, mr);
        check({tag, ".flag_n"},     {15'd0, flag_n}, {15'd0, n});
        check({tag, ".flag_z"},     {15'd0, flag_z}, {15'd0, z});
        check({tag, ".flag_v"},     {15'd0, flag_v}, {15'd0, v});
    endtask

    task automatic drive(input logic vld, input logic [15:0] res, input logic n, input logic v,
                         input logic [1:0] fc);
        ex_valid  = vld;
        ex_result = res;
        ex_n      = n;
        ex_v      = v;
        ex_fclass = fc;
    endtask

    task automatic check_br(input string tag, input logic bv, input logic [2:0] c,
                            input logic exp);
        br_valid = bv;
        br_cond  = c;
        #1;
        check(tag, {15'd0, br_taken}, {15'd0, exp});
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        br_valid = 1'b0;
        br_cond = 3'd0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00);
        tick();
        tick();
        check_state("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Saturated positive result: OV decided via bypass in the same cycle.
        rst = 1'b0;
        drive(1'b1, 16'h7FFF, 1'b0, 1'b1, 2'b10);
        check_br("ov_bypass", 1'b1, 3'b110, 1'b1);
        tick();
        check_state("sat_pos", 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1);

        drive(1'b1, 16'h8000, 1'b1, 1'b1, 2'b10);
        check_br("lt_bypass", 1'b1, 3'b011, 1'b1);
        tick();
        check_state("sat_neg", 1'b1, 16'h8000, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00);
        check_br("lt_reg", 1'b1, 3'b011, 1'b1);

        // Z-only update leaves N/V alone; LE sees the bypassed Z.
        drive(1'b1, 16'h0000, 1'b0, 1'b0, 2'b01);
        check_br("le_bypass", 1'b1, 3'b101, 1'b1);
        tick();
        check_state("z_only", 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1);

        drive(1'b1, 16'h1234, 1'b0, 1'b0, 2'b00);
        check_br("eq_fc00", 1'b1, 3'b001, 1'b1);
        tick();
        check_state("fc00", 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1);

        drive(1'b1, 16'h0005, 1'b0, 1'b0, 2'b11);
        check_br("ne_fc11", 1'b1, 3'b000, 1'b0);
        tick();
        check_state("fc11", 1'b1, 16'h0005, 1'b1, 1'b1, 1'b1);

        // Stalled candidate would clear Z if bypassed; EQ must still see Z=1.
        stall = 1'b1;
        drive(1'b1, 16'hABCD, 1'b0, 1'b0, 2'b10);
        for (int i = 0; i < 3; i++) begin
            check_br("stall_nobypass", 1'b1, 3'b001, 1'b1);
            tick();
            check_state("stall", 1'b1, 16'h0005, 1'b1, 1'b1, 1'b1);
        end
        flush = 1'b1;
        check_br("stflush_nobypass", 1'b1, 3'b001, 1'b1);
        tick();
        check_state("stall_flush", 1'b0, 16'h0005, 1'b1, 1'b1, 1'b1);

        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 16'h0001, 1'b0, 1'b0, 2'b10);
        tick();
        check_state("refill", 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        drive(1'b1, 16'h0009, 1'b1, 1'b1, 2'b10);
        check_br("flush_nobypass", 1'b1, 3'b011, 1'b0);
        tick();
        check_state("flush", 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
        flush = 1'b0;

        // Back-to-back commits, then a bubble.
        drive(1'b1, 16'h0000, 1'b0, 1'b1, 2'b10);
        tick();
        check_state("b2b_0", 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 16'hFFFF, 1'b1, 1'b0, 2'b10);
        tick();
        check_state("b2b_1", 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 16'h4444, 1'b0, 1'b1, 2'b10);
        tick();
        check_state("bubble", 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Reset discards a concurrent valid instruction; no bypass during reset.
        rst = 1'b1;
        drive(1'b1, 16'h0000, 1'b1, 1'b1, 2'b10);
        check_br("rst_nobypass", 1'b1, 3'b001, 1'b0);
        tick();
        check_state("rst_cycle", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00);
        check_br("eq_after_rst", 1'b1, 3'b001, 1'b0);
        tick();
        check_state("post_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Condition table with all flags clear.
        check_br("uncond_off", 1'b0, 3'b111, 1'b0);
        check_br("uncond_on",  1'b1, 3'b111, 1'b1);
        check_br("ne_clear",   1'b1, 3'b000, 1'b1);
        check_br("gt_clear",   1'b1, 3'b010, 1'b1);
        check_br("lt_clear",   1'b1, 3'b011, 1'b0);
        check_br("ge_clear",   1'b1, 3'b100, 1'b1);
        check_br("le_clear",   1'b1, 3'b101, 1'b0);
        check_br("ov_clear",   1'b1, 3'b110, 1'b0);

        // Negative result with overflow: GT/GE false, LE/LT/OV true, UNCOND true.
        drive(1'b1, 16'h9000, 1'b1, 1'b1, 2'b10);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 2'b00);
        check_br("gt_neg",     1'b1, 3'b010, 1'b0);
        check_br("ge_neg",     1'b1, 3'b100, 1'b0);
        check_br("le_neg",     1'b1, 3'b101, 1'b1);
        check_br("ov_set",     1'b1, 3'b110, 1'b1);
        check_br("uncond_neg", 1'b1, 3'b111, 1'b1);
        check_br("off_neg",    1'b0, 3'b011, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_flag_stage.md
EX_FLAG_STAGE -- requirements
Module: ex_flag_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have port ex_valid, input, 1, the EX-stage instruction is real (not a bubble).
REQ-004 SHALL have port ex_result, input, 16, saturated sum/difference or other ALU result.
REQ-005 SHALL have ports ex_n and ex_v, input, 1 each, the adder's N and V (saturation occurred) flags.
REQ-006 SHALL have port ex_fclass, input, 2, flag update class: 00 none, 01 Z only, 10 N/Z/V, 11 reserved (treated as 00).
REQ-007 SHALL have ports stall and flush, input, 1 each, pipeline control from the hazard unit.
REQ-008 SHALL have ports br_valid (input, 1) and br_cond (input, 3), a branch in ID requesting evaluation.
REQ-009 SHALL have ports mem_valid (output, 1) and mem_result (output, 16), the EX/MEM pipeline register.
REQ-010 SHALL have ports flag_n, flag_z and flag_v, output, 1 each, the architectural flag register.
REQ-011 SHALL have port br_taken, output, 1, the combinational branch decision.

Function
REQ-012 SHALL treat an EX instruction as committing when ex_valid=1, stall=0 and flush=0.
REQ-013 SHALL load mem_result<=ex_result and mem_valid<=1 on the rising edge when the instruction commits.
REQ-014 SHALL, when stall=0 and flush=1, load mem_valid<=0 and leave mem_result unchanged.
REQ-015 SHALL, when stall=0, flush=0 and ex_valid=0, load mem_valid<=0.
REQ-016 SHALL hold mem_valid, mem_result and all flags unchanged while stall=1 and flush=0.
REQ-017 SHALL give flush priority over stall: stall=1 with flush=1 loads mem_valid<=0 and updates no flag.
REQ-018 SHALL compute Z internally as (ex_result==16'h0000), ignoring any upstream Z.
REQ-019 SHALL, on commit with fclass 10, load flag_n<=ex_n, flag_z<=computed Z and flag_v<=ex_v.
REQ-020 SHALL, on commit with fclass 01, load flag_z only; on commit with fclass 00 or 11, load no flag.
REQ-021 SHALL define the effective flags as the values that will load on the next edge if a commit with a flag update is pending, else the register values (same-cycle bypass).
REQ-022 SHALL drive br_taken=0 when br_valid=0; otherwise br_taken SHALL be the br_cond function of the effective flags.
REQ-023 SHALL decode br_cond as: 000 NE (Z=0); 001 EQ (Z=1); 010 GT (Z=0 and N=0); 011 LT (N=1); 100 GE (Z=1 or (Z=0 and N=0)); 101 LE (N=1 or Z=1); 110 OV (V=1); 111 always.
REQ-024 SHALL give one-edge latency from the EX inputs to mem_* and flag_*, and zero latency to br_taken.
REQ-025 SHALL give back-to-back commits independent updates each cycle, with no bubble required.

Reset
REQ-026 SHALL, on a rising edge with rst=1, load mem_valid=0, mem_result=16'h0000 and flag_n=flag_z=flag_v=0, overriding stall, flush and any commit.
REQ-027 SHALL keep br_taken combinational during reset, evaluated on the effective flags; with rst=1 no commit is pending.
REQ-028 SHALL discard an instruction presented in the same cycle that rst=1, with no late update after reset deasserts.

Structure
REQ-029 SHALL place the fclass codes (FC_NONE, FC_Z, FC_NZV) and the br_cond codes (NE, EQ, GT, LT, GE, LE, OV, UNCOND) in a shared package used by the decoder.
REQ-030 SHALL implement the condition decode as a purely combinational sub-module br_cond_eval (inputs n/z/v/cond, output taken).
REQ-031 SHALL place the flag register, the EX/MEM register and the bypass mux in ex_flag_stage itself.

Verification
REQ-032 SHALL cover: ex_result=16'h7FFF, ex_v=1, ex_n=0, fclass=10, br_valid=1, cond=110 in the same cycle -> br_taken=1 via bypass; next edge flag_v=1, mem_result=16'h7FFF, mem_valid=1.
REQ-033 SHALL cover: ex_result=16'h8000, ex_n=1, ex_v=1, fclass=10, then cond=011 -> br_taken=1 and flag_z=0.
REQ-034 SHALL cover: after flags N=1,Z=0, commit ex_result=0, fclass=01 -> flag_z=1, flag_n remains 1; cond=101 -> br_taken=1.
REQ-035 SHALL cover: a commit candidate with stall=1 for 3 cycles -> mem_*/flags frozen and bypass off; stall+flush together -> mem_valid=0, flags unchanged.
REQ-036 SHALL cover: a valid fclass=10 instruction with rst=1 -> all outputs zero next edge; br_cond=001 afterwards -> br_taken=0.
REQ-037 SHALL cover: br_valid=0 with cond=111 -> br_taken=0; br_valid=1 with cond=111 -> br_taken=1 for any flag values.
